// File: rtl/mips_mem_arbiter_pkg.sv
// Shared constants and state type for the unified-memory arbiter.
// Optional round-robin IF/MEM arbitration is enabled by MEM_ARB_RR_EN.
package mips_mem_arb_pkg;

  localparam int REQ_IF  = 0;
  localparam int REQ_MEM = 1;
  localparam int REQ_LD  = 2;
  localparam int NREQ    = 3;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

endpackage

// File: rtl/mips_mem_arbiter_pick.sv
// Eligible-mask to one-hot winner: LD first, then MEM/IF.
// MEM_ARB_RR_EN: MEM and IF alternate when both are eligible.
module mips_arb_pick
  import mips_mem_arb_pkg::*;
(
  input  logic [NREQ-1:0] elig,
`ifdef MEM_ARB_RR_EN
  input  logic            rr_last,
`endif
  output logic [NREQ-1:0] win
);

  always_comb begin
    win = '0;
`ifdef MEM_ARB_RR_EN
    // rr_last=1 means MEM was granted last, so IF goes first on a tie
    priority case (1'b1)
      elig[REQ_LD]:
        win[REQ_LD] = 1'b1;
      elig[REQ_MEM] && (!elig[REQ_IF] || !rr_last):
        win[REQ_MEM] = 1'b1;
      elig[REQ_IF]:
        win[REQ_IF] = 1'b1;
      default:
        win = '0;
    endcase
`else
    priority case (1'b1)
      elig[REQ_LD]:  win[REQ_LD]  = 1'b1;
      elig[REQ_MEM]: win[REQ_MEM] = 1'b1;
      elig[REQ_IF]:  win[REQ_IF]  = 1'b1;
      default:       win = '0;
    endcase
`endif
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter for IF / MEM / LD with fixed access latency.
// Define MEM_ARB_RR_EN for round-robin between IF and MEM.
module mips_mem_arbiter
  import mips_mem_arb_pkg::*;
#(
  parameter int AW      = 10,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halted,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [DW-1:0]     rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata
);

  localparam int CW = $clog2(MEM_LAT + 1);

  arb_state_t      state;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] owner;
  logic            own_we;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] win;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
`ifdef MEM_ARB_RR_EN
  logic            rr_last;
`endif

  assign elig = req & {1'b1, 1'b1, !halted};

  mips_arb_pick u_pick (
    .elig    (elig),
`ifdef MEM_ARB_RR_EN
    .rr_last (rr_last),
`endif
    .win     (win)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) begin
        sel_we    = we[i] && (i != REQ_IF);
        sel_addr  = addr[i*AW +: AW];
        sel_wdata = wdata[i*DW +: DW];
      end
    end
  end

  // Memory data is passed straight through in the done cycle only
  assign rdata = (|done && !own_we) ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      cnt       <= '0;
      owner     <= '0;
      own_we    <= 1'b0;
      gnt       <= '0;
      done      <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef MEM_ARB_RR_EN
      rr_last   <= 1'b0;
`endif
    end else begin
      gnt    <= '0;
      done   <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (|win) begin
            gnt       <= win;
            owner     <= win;
            own_we    <= sel_we;
            mem_en    <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            cnt       <= CW'(MEM_LAT);
            state     <= ARB_BUSY;
`ifdef MEM_ARB_RR_EN
            if (win[REQ_IF] || win[REQ_MEM])
              rr_last <= win[REQ_MEM];
`endif
          end
        end
        ARB_BUSY: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            done  <= owner;
            owner <= '0;
            state <= ARB_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed + randomized bench for mips_mem_arbiter with a transaction-level
// reference model; honours MEM_ARB_RR_EN for the expected grant order.
module tb_mips_mem_arbiter;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          halted;
  logic [2:0]    req, we;
  logic [29:0]   addr;
  logic [95:0]   wdata;
  logic [2:0]    gnt, done;
  logic [31:0]   rdata;
  logic          mem_en, mem_we;
  logic [9:0]    mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mips_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .halted    (halted),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] finit(input int a);
    return (a * 32'h01010101) ^ 32'h0000005a;
  endfunction

  // Memory device: LAT-cycle read pipeline, unwritten words hold finit()
  logic [31:0] memd [1024];
  logic        wrtn [1024];
  logic [31:0] pipe [LAT];

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      memd[mem_addr] <= mem_wdata;
      wrtn[mem_addr] <= 1'b1;
    end
    pipe[0] <= wrtn[mem_addr] === 1'b1 ? memd[mem_addr] : finit(int'(mem_addr));
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[LAT-1];

  // Reference model state
  logic [31:0] ref_mem [int];
  bit          mdl_last_mem;

  function automatic logic [31:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : finit(a);
  endfunction

  task automatic mpick(input logic [2:0] p, output int w);
    w = -1;
    if (p[2]) w = 2;
`ifdef MEM_ARB_RR_EN
    else if (p[1] && p[0]) w = mdl_last_mem ? 0 : 1;
`endif
    else if (p[1]) w = 1;
    else if (p[0]) w = 0;
    if (w == 0) mdl_last_mem = 1'b0;
    if (w == 1) mdl_last_mem = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive a request set, predict grant order/timing, check every cycle
  task automatic batch(input logic [2:0] rq, input logic [2:0] wv,
                       input logic [29:0] av, input logic [95:0] dv,
                       input int ng, input bit persist);
    int          ord[$];
    logic [31:0] erd[$];
    bit          ewr[$];
    logic [2:0]  pend, oh;
    int          w, k, ph;
    int          a;
    bit          wr;
    pend = rq;
    for (int i = 0; i < ng; i++) begin
      mpick(pend, w);
      a  = int'(av[w*10 +: 10]);
      wr = wv[w] && (w != 0);
      ord.push_back(w);
      ewr.push_back(wr);
      if (wr) begin
        ref_mem[a] = dv[w*32 +: 32];
        erd.push_back(32'h0);
      end else erd.push_back(ref_rd(a));
      if (!persist) pend[w] = 1'b0;
    end
    req = rq; we = wv; addr = av; wdata = dv;
    for (int c = 1; c <= ng * (LAT + 1); c++) begin
      @(negedge clk);
      k  = (c - 1) / (LAT + 1);
      ph = (c - 1) % (LAT + 1);
      oh = 3'b001 << ord[k];
      chk("gnt", 32'(gnt), ph == 0 ? 32'(oh) : 32'h0);
      chk("mem_en", 32'(mem_en), 32'(ph == 0));
      chk("mem_we", 32'(mem_we), 32'(ph == 0 && ewr[k]));
      chk("done", 32'(done), ph == LAT ? 32'(oh) : 32'h0);
      if (ph == 0) begin
        chk("mem_addr", 32'(mem_addr), 32'(av[ord[k]*10 +: 10]));
        if (ewr[k]) chk("mem_wdata", mem_wdata, dv[ord[k]*32 +: 32]);
        if (!persist) req[ord[k]] = 1'b0;
      end
      if (ph == LAT) chk("rdata", rdata, erd[k]);
    end
    req = '0;
  endtask

  logic [2:0]  rq, wv;
  logic [29:0] av;
  logic [95:0] dv;

  initial begin
    rst_n = 1'b0; halted = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    mdl_last_mem = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // LD preloads mem[120]=85, then MEM reads it back
    batch(3'b100, 3'b100, {10'd120, 10'd0, 10'd0}, {32'd85, 64'd0}, 1, 0);
    batch(3'b010, 3'b000, {10'd0, 10'd120, 10'd0}, 96'd0, 1, 0);
    // write-then-read at 121
    batch(3'b100, 3'b100, {10'd121, 10'd0, 10'd0}, {32'd42, 64'd0}, 1, 0);
    batch(3'b010, 3'b000, {10'd0, 10'd121, 10'd0}, 96'd0, 1, 0);
    // IF write request is forced to a read
    batch(3'b001, 3'b001, {20'd0, 10'd121}, {64'd0, 32'hdead}, 1, 0);
    // three-way contention
    batch(3'b111, 3'b000, {10'd120, 10'd121, 10'd7}, 96'd0, 3, 0);

    // halt mask
    halted = 1'b1; req = 3'b001; addr = {20'd0, 10'd9};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("halt_gnt", 32'(gnt), 0);
      chk("halt_mem_en", 32'(mem_en), 0);
    end
    halted = 1'b0;
    batch(3'b001, 3'b000, {20'd0, 10'd9}, 96'd0, 1, 0);

    // IF and MEM both requesting continuously
    batch(3'b011, 3'b000, {10'd0, 10'd120, 10'd121}, 96'd0, 4, 1);

    // reset in the middle of an access
    req = 3'b010; we = '0; addr = {10'd0, 10'd5, 10'd0};
    @(negedge clk);
    chk("pre_rst_gnt", 32'(gnt), 32'b010);
    req = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 0);
    chk("arst_mem_en", 32'(mem_en), 0);
    chk("arst_done", 32'(done), 0);
    mdl_last_mem = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      chk("abandon_done", 32'(done), 0);
    end

    // randomized request sets against the model
    for (int n = 0; n < 30; n++) begin
      rq = 3'($urandom_range(1, 7));
      wv = 3'($urandom);
      for (int r = 0; r < 3; r++) begin
        av[r*10 +: 10] = 10'($urandom_range(0, 15));
        dv[r*32 +: 32] = $urandom;
      end
      batch(rq, wv, av, dv, $countones(rq), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
